// File: rtl/gate_truth_sweep.sv
// gate_truth_sweep: walks every input combination of an N-input gate,
// lets each vector settle, then compares the gate output with the
// function selected by the mode latched at start. It reports the
// mismatch count and the first failing vector.
module gate_truth_sweep #(
    parameter int N      = 2,
    parameter int SETTLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic [2:0]   mode,
    output logic [N-1:0] stim,
    input  logic         dut_y,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [N:0]   err_count,
    output logic [N-1:0] first_fail,
    output logic         first_fail_valid
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_CHECK,
        S_DONE
    } state_t;

    // The settle counter runs 0..SETTLE-1 while a vector is held.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t       r_state;
    logic [2:0]   r_mode;
    logic [3:0]   r_settle_cnt;
    logic [N-1:0] r_stim;
    logic         r_busy;
    logic         r_done;
    logic         r_pass;
    logic [N:0]   r_err_count;
    logic [N-1:0] r_first_fail;
    logic         r_first_fail_valid;

    logic         w_expected;
    logic         w_mismatch;
    logic         w_last_vec;
    logic         w_settle_end;
    logic [N:0]   w_err_next;

    // Reference output of the selected gate for one input vector.
    function automatic logic gate_expect(input logic [2:0] m, input logic [N-1:0] v);
        case (m)
            3'd0:    return &v;
            3'd1:    return |v;
            3'd2:    return ~&v;
            3'd3:    return ~|v;
            3'd4:    return ^v;
            3'd5:    return ~^v;
            3'd6:    return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    assign w_expected   = gate_expect(r_mode, r_stim);
    assign w_mismatch   = (dut_y != w_expected);
    assign w_last_vec   = (r_stim == {N{1'b1}});
    assign w_settle_end = (r_settle_cnt == SETTLE_LAST);
    assign w_err_next   = r_err_count + {{N{1'b0}}, w_mismatch};

    // Sweep sequencer: owns the state, the stimulus and every reported result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state            <= S_IDLE;
            r_mode             <= 3'd0;
            r_settle_cnt       <= 4'd0;
            r_stim             <= '0;
            r_busy             <= 1'b0;
            r_done             <= 1'b0;
            r_pass             <= 1'b0;
            r_err_count        <= '0;
            r_first_fail       <= '0;
            r_first_fail_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state            <= S_DRIVE;
                        r_mode             <= mode;
                        r_settle_cnt       <= 4'd0;
                        r_stim             <= '0;
                        r_busy             <= 1'b1;
                        r_done             <= 1'b0;
                        r_pass             <= 1'b0;
                        r_err_count        <= '0;
                        r_first_fail       <= '0;
                        r_first_fail_valid <= 1'b0;
                    end
                end
                S_DRIVE: begin
                    if (abort) begin
                        // Partial err_count/first_fail are kept for inspection.
                        r_state      <= S_IDLE;
                        r_busy       <= 1'b0;
                        r_done       <= 1'b0;
                        r_pass       <= 1'b0;
                        r_stim       <= '0;
                        r_settle_cnt <= 4'd0;
                    end else if (w_settle_end) begin
                        r_settle_cnt <= 4'd0;
                        r_state      <= S_CHECK;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + 4'd1;
                    end
                end
                S_CHECK: begin
                    if (abort) begin
                        r_state      <= S_IDLE;
                        r_busy       <= 1'b0;
                        r_done       <= 1'b0;
                        r_pass       <= 1'b0;
                        r_stim       <= '0;
                        r_settle_cnt <= 4'd0;
                    end else begin
                        r_err_count <= w_err_next;
                        if (w_mismatch && !r_first_fail_valid) begin
                            r_first_fail       <= r_stim;
                            r_first_fail_valid <= 1'b1;
                        end
                        if (w_last_vec) begin
                            // stim stays at all-ones while results are held.
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_pass  <= (w_err_next == '0);
                        end else begin
                            r_stim  <= r_stim + {{(N-1){1'b0}}, 1'b1};
                            r_state <= S_DRIVE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign stim             = r_stim;
    assign busy             = r_busy;
    assign done             = r_done;
    assign pass             = r_pass;
    assign err_count        = r_err_count;
    assign first_fail       = r_first_fail;
    assign first_fail_valid = r_first_fail_valid;

endmodule
